// File: rtl/ai_accel_pkg.sv
// Shared constants for the AI accelerator Wishbone front end.
// Register map, CTRL/STATUS bit positions and datapath width.
package ai_accel_pkg;

    localparam int DATA_W = 32;

    localparam logic [7:0] REG_CTRL     = 8'h00;
    localparam logic [7:0] REG_STATUS   = 8'h04;
    localparam logic [7:0] REG_DATA_IN  = 8'h08;
    localparam logic [7:0] REG_DATA_OUT = 8'h0C;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CLR    = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_IN_CNT    = 0;
    localparam int ST_OUT_CNT   = 8;
    localparam int ST_IN_FULL   = 16;
    localparam int ST_OUT_EMPTY = 17;
    localparam int ST_OVF       = 18;
    localparam int ST_UNF       = 19;

    function automatic logic [DATA_W-1:0] byte_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/ai_wb_frontend_if.sv
// Wishbone slave port plus operand/result streams of the front end.
// Names keep the bus-facing i/o suffixes used by the SoC wrapper.
interface ai_wb_frontend_if;
    import ai_accel_pkg::*;

    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic              wb_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wb_addr_i;
    logic [DATA_W-1:0] wb_data_i;
    logic [DATA_W-1:0] wb_data_o;
    logic              wb_ack;
    logic [DATA_W-1:0] op_data_o;
    logic              op_valid_o;
    logic              op_ready_i;
    logic [DATA_W-1:0] res_data_i;
    logic              res_valid_i;
    logic              res_ready_o;
    logic              irq_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wbs_sel_i, wb_addr_i, wb_data_i,
        input  wb_data_o, wb_ack,
        input  op_data_o, op_valid_o,
        output op_ready_i,
        output res_data_i, res_valid_i,
        input  res_ready_o, irq_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wbs_sel_i, wb_addr_i, wb_data_i,
        output wb_data_o, wb_ack,
        output op_data_o, op_valid_o,
        input  op_ready_i,
        input  res_data_i, res_valid_i,
        output res_ready_o, irq_o
    );

endinterface

// File: rtl/ai_sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush.
// Push when full and pop when empty are ignored.
module ai_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/ai_wb_frontend.sv
// Wishbone register window feeding the accelerator core through
// an operand FIFO and collecting its results in a result FIFO.
module ai_wb_frontend
    import ai_accel_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3200_0000,
    parameter int          DEPTH     = 4
) (
    input logic             wb_clk_i,
    input logic             wb_rst_ni,
    ai_wb_frontend_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              r_ack;
    logic [DATA_W-1:0] r_rdata;
    logic              r_en;
    logic              r_irq_en;
    logic              r_ovf;
    logic              r_unf;
    logic              r_irq;

    logic              w_req, w_wr, w_rd;
    logic [7:0]        w_off;
    logic              w_ctrl_wr, w_clear, w_st_wr;
    logic              w_push_req, w_pop_req;
    logic              w_op_xfer, w_res_xfer;
    logic              w_in_full, w_in_empty, w_out_full, w_out_empty;
    logic [CW-1:0]     w_in_cnt, w_out_cnt;
    logic [DATA_W-1:0] w_in_head, w_out_head, w_status, w_rd_val;

    assign w_off = bus.wb_addr_i[7:0];
    assign w_req = bus.wb_cyc_i & bus.wb_stb_i & ~r_ack
                 & (bus.wb_addr_i[31:8] == BASE_ADDR[31:8]);
    assign w_wr  = w_req & bus.wb_we_i;
    assign w_rd  = w_req & ~bus.wb_we_i;

    assign w_ctrl_wr  = w_wr & (w_off == REG_CTRL) & bus.wbs_sel_i[0];
    assign w_clear    = w_ctrl_wr & bus.wb_data_i[CTRL_CLR];
    assign w_st_wr    = w_wr & (w_off == REG_STATUS) & bus.wbs_sel_i[2];
    assign w_push_req = w_wr & (w_off == REG_DATA_IN);
    assign w_pop_req  = w_rd & (w_off == REG_DATA_OUT);

    // A clear discards whatever the core offers or takes on that edge
    assign w_op_xfer  = bus.op_valid_o & bus.op_ready_i & ~w_clear;
    assign w_res_xfer = bus.res_valid_i & ~w_out_full & ~w_clear;

    ai_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_flush (w_clear),
        .i_push  (w_push_req),
        .i_pop   (w_op_xfer),
        .i_data  (bus.wb_data_i & byte_mask(bus.wbs_sel_i)),
        .o_data  (w_in_head),
        .o_full  (w_in_full),
        .o_empty (w_in_empty),
        .o_count (w_in_cnt)
    );

    ai_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_ni),
        .i_flush (w_clear),
        .i_push  (w_res_xfer),
        .i_pop   (w_pop_req),
        .i_data  (bus.res_data_i),
        .o_data  (w_out_head),
        .o_full  (w_out_full),
        .o_empty (w_out_empty),
        .o_count (w_out_cnt)
    );

    always_comb begin
        w_status                      = '0;
        w_status[ST_IN_CNT +: CW]     = w_in_cnt;
        w_status[ST_OUT_CNT +: CW]    = w_out_cnt;
        w_status[ST_IN_FULL]          = w_in_full;
        w_status[ST_OUT_EMPTY]        = w_out_empty;
        w_status[ST_OVF]              = r_ovf;
        w_status[ST_UNF]              = r_unf;
        w_rd_val = '0;
        unique case (1'b1)
            w_off == REG_CTRL: begin
                w_rd_val[CTRL_EN]     = r_en;
                w_rd_val[CTRL_IRQ_EN] = r_irq_en;
            end
            w_off == REG_STATUS:   w_rd_val = w_status;
            w_off == REG_DATA_OUT: w_rd_val = w_out_empty ? '0 : w_out_head;
            default:               w_rd_val = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack    <= 1'b0;
            r_rdata  <= '0;
            r_en     <= 1'b0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_ack   <= w_req;
            r_rdata <= w_rd ? w_rd_val : '0;
            r_irq   <= r_irq_en & ~w_out_empty;
            if (w_ctrl_wr) begin
                r_en     <= bus.wb_data_i[CTRL_EN];
                r_irq_en <= bus.wb_data_i[CTRL_IRQ_EN];
            end
            if (w_clear) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                if (w_push_req & w_in_full) r_ovf <= 1'b1;
                else if (w_st_wr & bus.wb_data_i[ST_OVF]) r_ovf <= 1'b0;
                if (w_pop_req & w_out_empty) r_unf <= 1'b1;
                else if (w_st_wr & bus.wb_data_i[ST_UNF]) r_unf <= 1'b0;
            end
        end
    end

    assign bus.wb_ack      = r_ack;
    assign bus.wb_data_o   = r_rdata;
    assign bus.op_valid_o  = r_en & ~w_in_empty;
    assign bus.op_data_o   = w_in_head;
    assign bus.res_ready_o = ~w_out_full;
    assign bus.irq_o       = r_irq;

endmodule

// File: tb/tb_ai_wb_frontend.sv
// Randomized and directed bench for ai_wb_frontend against a
// queue-based model of the register window and both FIFOs.
module tb_ai_wb_frontend;

    localparam logic [31:0] BASE  = 32'h3200_0000;
    localparam int          DEPTH = 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    ai_wb_frontend_if bus ();

    ai_wb_frontend #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] in_q[$];
    logic [31:0] out_q[$];
    bit          m_en, m_irq_en, m_ovf, m_unf, m_ack, m_irq;
    logic [31:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'(in_q.size()) + (32'(out_q.size()) << 8);
        if (in_q.size() == DEPTH) s = s + 32'h0001_0000;
        if (out_q.size() == 0)    s = s + 32'h0002_0000;
        if (m_ovf)                s = s + 32'h0004_0000;
        if (m_unf)                s = s + 32'h0008_0000;
        return s;
    endfunction

    // Applies one clock edge worth of register-map rules to the model
    task automatic model_step();
        bit          req, clr, push, pop, opx, resx, irq_nx;
        logic [31:0] d, rd, pw;
        logic [7:0]  off;
        d   = bus.wb_data_i;
        off = bus.wb_addr_i[7:0];
        req = bus.wb_cyc_i && bus.wb_stb_i && !m_ack
           && (bus.wb_addr_i[31:8] == BASE[31:8]);
        clr = 0; push = 0; pop = 0; rd = 0; pw = 0;
        irq_nx = m_irq_en && out_q.size() != 0;
        opx    = m_en && in_q.size() != 0 && bus.op_ready_i;
        resx   = bus.res_valid_i && out_q.size() < DEPTH;
        if (req && bus.wb_we_i) begin
            if (off == 8'h00 && bus.wbs_sel_i[0]) begin
                m_en = d[0]; m_irq_en = d[2]; clr = d[1];
            end else if (off == 8'h04 && bus.wbs_sel_i[2]) begin
                if (d[18]) m_ovf = 0;
                if (d[19]) m_unf = 0;
            end else if (off == 8'h08) begin
                if (in_q.size() == DEPTH) m_ovf = 1;
                else begin
                    push = 1;
                    for (int b = 0; b < 4; b++)
                        if (bus.wbs_sel_i[b]) pw[8*b +: 8] = d[8*b +: 8];
                end
            end
        end else if (req) begin
            if (off == 8'h00) rd = {29'b0, m_irq_en, 1'b0, m_en};
            else if (off == 8'h04) rd = m_status();
            else if (off == 8'h0C) begin
                if (out_q.size() == 0) m_unf = 1;
                else begin rd = out_q[0]; pop = 1; end
            end
        end
        if (clr) begin
            in_q.delete(); out_q.delete(); m_ovf = 0; m_unf = 0;
        end else begin
            if (opx)  void'(in_q.pop_front());
            if (push) in_q.push_back(pw);
            if (pop)  void'(out_q.pop_front());
            if (resx) out_q.push_back(bus.res_data_i);
        end
        m_ack = req; m_rdata = rd; m_irq = irq_nx;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("ack", bus.wb_ack, m_ack);
        chk("rdata", bus.wb_data_o, m_rdata);
        chk("op_valid", bus.op_valid_o, m_en && in_q.size() != 0);
        if (m_en && in_q.size() != 0) chk("op_data", bus.op_data_o, in_q[0]);
        chk("res_ready", bus.res_ready_o, out_q.size() < DEPTH);
        chk("irq", bus.irq_o, m_irq);
    endtask

    task automatic wb_xfer(input bit we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] sel,
                           output logic [31:0] rd);
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we;
        bus.wb_addr_i = a; bus.wb_data_i = d; bus.wbs_sel_i = sel;
        tick();
        rd = bus.wb_data_o;
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        tick();
    endtask

    task automatic wb_wr(input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] sel);
        logic [31:0] unused;
        wb_xfer(1, a, d, sel, unused);
    endtask

    task automatic wb_rd(input logic [31:0] a, output logic [31:0] rd);
        wb_xfer(0, a, 32'h0, 4'hF, rd);
    endtask

    logic [31:0] rv;

    initial begin
        n_chk = 0; n_fail = 0;
        clk = 0; rst_n = 0;
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
        bus.wbs_sel_i = 0; bus.wb_addr_i = 0; bus.wb_data_i = 0;
        bus.op_ready_i = 0; bus.res_data_i = 0; bus.res_valid_i = 0;
        m_en = 0; m_irq_en = 0; m_ovf = 0; m_unf = 0; m_ack = 0;
        m_irq = 0; m_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", bus.wb_ack, 0);
        chk("rst_data", bus.wb_data_o, 0);
        chk("rst_op_valid", bus.op_valid_o, 0);
        chk("rst_op_data", bus.op_data_o, 0);
        chk("rst_res_ready", bus.res_ready_o, 1);
        chk("rst_irq", bus.irq_o, 0);
        rst_n = 1;

        wb_rd(BASE + 32'h04, rv);
        chk("status_reset", rv, 32'h0002_0000);

        wb_wr(BASE + 32'h00, 32'h1, 4'hF);
        wb_wr(BASE + 32'h08, 32'hDEAD_BEEF, 4'b0011);
        chk("op_data_masked", bus.op_data_o, 32'h0000_BEEF);
        chk("op_valid_on", bus.op_valid_o, 1);
        bus.op_ready_i = 1;
        tick();
        bus.op_ready_i = 0;
        chk("op_valid_off", bus.op_valid_o, 0);

        wb_wr(BASE + 32'h00, 32'h0, 4'hF);
        for (int i = 0; i < 5; i++) wb_wr(BASE + 32'h08, $urandom, 4'hF);
        wb_rd(BASE + 32'h04, rv);
        chk("status_ovf", rv, 32'h0007_0004);
        wb_wr(BASE + 32'h04, 32'h0004_0000, 4'hF);
        wb_rd(BASE + 32'h04, rv);
        chk("status_ovf_clr", rv, 32'h0003_0004);

        wb_wr(BASE + 32'h00, 32'h4, 4'hF);
        bus.res_data_i = 32'h1234_5678; bus.res_valid_i = 1;
        tick();
        bus.res_valid_i = 0;
        tick();
        chk("irq_rise", bus.irq_o, 1);
        wb_rd(BASE + 32'h0C, rv);
        chk("data_out", rv, 32'h1234_5678);
        chk("irq_fall", bus.irq_o, 0);
        wb_rd(BASE + 32'h0C, rv);
        chk("data_out_empty", rv, 0);
        wb_rd(BASE + 32'h04, rv);
        chk("status_unf", rv, 32'h000B_0004);

        for (int i = 0; i < 4; i++) begin
            bus.res_data_i = $urandom; bus.res_valid_i = 1;
            tick();
        end
        bus.res_valid_i = 0;
        chk("res_ready_full", bus.res_ready_o, 0);
        wb_wr(BASE + 32'h00, 32'h2, 4'hF);
        wb_rd(BASE + 32'h04, rv);
        chk("status_clear", rv, 32'h0002_0000);
        chk("res_ready_clear", bus.res_ready_o, 1);

        wb_wr(32'h3300_0008, 32'hCAFE_F00D, 4'hF);
        wb_rd(BASE + 32'h04, rv);
        chk("no_push_outside", rv, 32'h0002_0000);
        wb_rd(BASE + 32'h40, rv);
        chk("unmapped_read", rv, 0);

        for (int it = 0; it < 400; it++) begin
            bus.op_ready_i  = 1'($urandom_range(0, 1));
            bus.res_valid_i = 1'($urandom_range(0, 1));
            bus.res_data_i  = $urandom;
            case ($urandom_range(0, 9))
                0: wb_wr(BASE, ($urandom & 32'h5)
                         | (($urandom_range(0, 15) == 0) ? 32'h2 : 32'h0),
                         4'($urandom));
                1: wb_wr(BASE + 32'h04, $urandom, 4'($urandom));
                2, 3, 4: wb_wr(BASE + 32'h08, $urandom, 4'($urandom));
                5, 6: wb_rd(BASE + 32'h0C, rv);
                7: wb_rd(BASE + 32'h04, rv);
                8: wb_xfer(1'($urandom_range(0, 1)),
                           BASE + (32'($urandom_range(4, 63)) << 2),
                           $urandom, 4'hF, rv);
                default: begin
                    if ($urandom_range(0, 1) == 0) tick();
                    else wb_wr(32'h3300_0000 | 32'($urandom_range(0, 255)),
                               $urandom, 4'hF);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
